cache_line_arbiter: RTL and testbench
=====================================

# cache_line_arbiter

Shares one 256-bit cache-line memory port between two line-granular requesters: port 0 is the instruction cache and port 1 is the data cache. It sits between the caches' downward-facing ports and the memory / burst adapter. It grants one whole-line transaction at a time, using a two-state FSM with round-robin tie-break. The memory command is registered and line-aligned, and the memory response is routed back combinationally to the owning requester only.

## Interface
- NUM_REQ, 2: number of requesters; fixed at 2 in this revision.
- LINE_BITS, 256: cache-line width in bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_addr  in  [NUM_REQ][32]  requester line address; bits [4:0] are ignored.
- req_read  in  [NUM_REQ]  line read request, held until req_resp.
- req_write  in  [NUM_REQ]  line write request, held until req_resp.
- req_wdata  in  [NUM_REQ][LINE_BITS]  write line, stable while req_write is high.
- req_rdata  out  [LINE_BITS]  broadcast of mem_rdata; valid only where req_resp is high.
- req_resp  out  [NUM_REQ]  one-cycle completion, at most one bit high.
- mem_addr  out  32  registered address, with [4:0] forced to 0.
- mem_read  out  1  registered; held until mem_resp.
- mem_write  out  1  registered; held until mem_resp.
- mem_wdata  out  LINE_BITS  registered write line.
- mem_rdata  in  LINE_BITS  memory read line, valid with mem_resp.
- mem_resp  in  1  one-cycle completion from memory.

## Operation
- FSM states:
  - ARB_IDLE: no memory command outstanding.
  - ARB_BUSY: one memory command outstanding, owned by `grant`.
- ARB_IDLE:
  - A requester is active when its req_read or req_write is high.
  - If exactly one requester is active, grant it.
  - If both are active, grant the one that is not `last_grant`.
  - On the clock edge: capture mem_addr = {req_addr[g][31:5], 5'b0} and mem_wdata = req_wdata[g].
  - On the same edge: set mem_write = req_write[g] and mem_read = !req_write[g]. Write wins if a requester illegally asserts both.
  - On the same edge: set grant = g, last_grant = g, and go to ARB_BUSY.
- ARB_BUSY:
  - The memory command registers are held constant.
  - Requester inputs are ignored.
  - On mem_resp: req_resp[grant] = 1 in the same cycle, req_rdata = mem_rdata in the same cycle.
  - At the next edge: clear mem_read and mem_write, return to ARB_IDLE.
- req_resp is 0 in every other case, including mem_resp arriving in ARB_IDLE (spurious; ignored).
- Requesters deassert in the cycle after req_resp, so the ARB_IDLE cycle after a completion sees only genuinely new requests.
- A requester dropping its request before req_resp is illegal. The arbiter still completes the memory transaction, and the response pulse is still driven.
- The arbiter does no data merging or buffering. Write lines pass through unchanged.

## Timing
- Reset (rst_n low, asynchronous):
  - state = ARB_IDLE, grant = 0, last_grant = 1, so port 0 wins the first tie.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - req_resp = 0; req_rdata follows mem_rdata.
- Reset mid-transaction: the memory command drops immediately and the in-flight response is never forwarded. The memory side must tolerate the abort.
- Request to command latency: a request seen in ARB_IDLE in cycle t produces mem_read or mem_write high in cycle t+1.
- Response latency: mem_resp in cycle m produces req_resp in cycle m (combinational). The command is low in m+1, and a new grant can take effect at m+2.
- Minimum occupancy is 2 cycles per transaction when memory responds in the first command cycle.
- Fairness: under continuous contention the grants alternate 0,1,0,1. No requester waits more than one full transaction.

## Structure
- Add to the shared cache_types package:
  - arb_state_t {ARB_IDLE, ARB_BUSY}
  - localparam LINE_BITS = 256
  - localparam OFFSET_BITS = 5
- One sub-module, rr_pick2: combinational two-way round-robin picker with inputs (active[1:0], last) and outputs (valid, pick). It is unit-testable alone.
- All state lives in cache_line_arbiter, in a single always_ff on clk / negedge rst_n.

## Test plan
- Single read: port 0 reads 0x0000_1234, memory responds after 3 cycles with pattern A.
  - mem_addr = 0x0000_1220 and mem_read = 1 from t+1.
  - req_resp = 2'b01 for one cycle with req_rdata = A.
  - mem_read = 0 the following cycle.
- Single write: port 1 writes 0x8000_0040 with line B. Expect mem_write = 1, mem_wdata = B, and req_resp = 2'b10 on mem_resp.
- Contention: both ports request in the same cycle, out of reset, for 4 back-to-back transactions. Expect the grant order 0,1,0,1 and never two resp bits high at once.
- Mid-wait change: port 1 changes req_addr while port 0 is being served. Expect mem_addr unchanged until port 0's completion, then port 1's new aligned address.
- Reset abort: assert rst_n low while ARB_BUSY with mem_read = 1. Expect mem_read = 0 immediately, and a late mem_resp after reset to produce no req_resp.
- Read+write both high on port 0: expect mem_write = 1, mem_read = 0.

Source files
------------

// File: rtl/cache_line_arbiter_pkg.sv
// Shared types and constants for the two-port cache-line arbiter.
package cache_line_arbiter_pkg;

  localparam int NUM_REQ     = 2;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int ADDR_BITS   = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_arbiter_if.sv
// Requester-side and memory-side line buses of the arbiter; master is the
// environment (caches + memory), slave is the arbiter itself.
interface cache_line_arbiter_if;
  import cache_line_arbiter_pkg::*;

  logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ-1:0]                req_read;
  logic [NUM_REQ-1:0]                req_write;
  logic [NUM_REQ-1:0][LINE_BITS-1:0] req_wdata;
  logic [LINE_BITS-1:0]              req_rdata;
  logic [NUM_REQ-1:0]                req_resp;

  logic [ADDR_BITS-1:0]              mem_addr;
  logic                              mem_read;
  logic                              mem_write;
  logic [LINE_BITS-1:0]              mem_wdata;
  logic [LINE_BITS-1:0]              mem_rdata;
  logic                              mem_resp;

  modport slave (
    input  req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/cache_line_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone active port wins,
// on a tie the port that did not win last time is picked.
module rr_pick2 (
  input  logic [1:0] active_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       pick_o
);

  assign valid_o = |active_i;
  assign pick_o  = (&active_i) ? ~last_i : active_i[1];

endmodule

// File: rtl/cache_line_arbiter.sv
// Grants one whole-line memory transaction at a time to the I-cache (port 0)
// or D-cache (port 1); command is registered, response is routed back combinationally.
module cache_line_arbiter
  import cache_line_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cache_line_arbiter_if.slave  bus
);

  arb_state_t           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]   active;
  logic [NUM_REQ-1:0]   resp;
  logic                 pick_vld;
  logic                 pick;

  assign active = bus.req_read | bus.req_write;

  rr_pick2 u_pick (
    .active_i (active),
    .last_i   (last_q),
    .valid_o  (pick_vld),
    .pick_o   (pick)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp        = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_d     = pick;
          last_d      = pick;
          mem_addr_d  = line_align(bus.req_addr[pick]);
          mem_wdata_d = bus.req_wdata[pick];
          // Write takes priority when a requester illegally raises both.
          mem_write_d = bus.req_write[pick];
          mem_read_d  = ~bus.req_write[pick];
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (bus.mem_resp) begin
          resp[grant_q] = 1'b1;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          state_d       = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_resp  = resp;
  assign bus.req_rdata = bus.mem_rdata;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Scenario-driven bench for cache_line_arbiter with a queue of expected grants.
module tb_cache_line_arbiter;
  import cache_line_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_arbiter_if bus();

  cache_line_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]           resp;
    logic [31:0]          addr;
    logic                 wr;
    logic [LINE_BITS-1:0] wdata;
    logic [LINE_BITS-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [LINE_BITS-1:0] mk_line(input logic [31:0] seed);
    logic [LINE_BITS-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (seed * 32'h9E37_79B9) + 32'(i);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req_addr  = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    bus.mem_rdata = mk_line(77);
    bus.mem_resp  = 1'b1;
    @(negedge clk);
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL rst_mem_read: got %b want 0", bus.mem_read); else n_pass++;
    n_total++; if (bus.mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== '0) $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); else n_pass++;
    n_total++; if (bus.req_resp !== 2'b00) $display("FAIL rst_req_resp: got %b want 00", bus.req_resp); else n_pass++;
    n_total++; if (bus.req_rdata !== mk_line(77)) $display("FAIL rst_rdata_follow: got %h want %h", bus.req_rdata, mk_line(77)); else n_pass++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_resp !== 2'b00) $display("FAIL spurious_resp_idle: got %b want 00", bus.req_resp); else n_pass++;
    tick();
    bus.mem_resp = 1'b0;
  endtask

  task automatic test_single_read();
    exp_t e;
    e = '{resp: 2'b01, addr: 32'h0000_1220, wr: 1'b0, wdata: '0, rdata: mk_line(1)};
    tick();
    bus.req_addr[0] = 32'h0000_1234;
    bus.req_read[0] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL rd_no_cmd_yet: got %b want 0", bus.mem_read); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (bus.mem_read !== 1'b1) $display("FAIL rd_cmd_t1: got %b want 1", bus.mem_read); else n_pass++;
    n_total++; if (bus.mem_write !== 1'b0) $display("FAIL rd_no_write: got %b want 0", bus.mem_write); else n_pass++;
    n_total++; if (bus.mem_addr !== sb[0].addr) $display("FAIL rd_addr: got %h want %h", bus.mem_addr, sb[0].addr); else n_pass++;
    tick();
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = mk_line(1);
    @(negedge clk);
    n_total++; if (bus.req_resp !== sb[0].resp) $display("FAIL rd_resp: got %b want %b", bus.req_resp, sb[0].resp); else n_pass++;
    n_total++; if (bus.req_rdata !== sb[0].rdata) $display("FAIL rd_rdata: got %h want %h", bus.req_rdata, sb[0].rdata); else n_pass++;
    void'(sb.pop_front());
    tick();
    bus.mem_resp    = 1'b0;
    bus.req_read[0] = 1'b0;
    @(negedge clk);
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL rd_cmd_clear: got %b want 0", bus.mem_read); else n_pass++;
    n_total++; if (bus.req_resp !== 2'b00) $display("FAIL rd_resp_one_cycle: got %b want 00", bus.req_resp); else n_pass++;
  endtask

  task automatic test_single_write();
    exp_t e;
    bit   ok;
    e = '{resp: 2'b10, addr: 32'h8000_0040, wr: 1'b1, wdata: mk_line(2), rdata: '0};
    tick();
    bus.req_addr[1]  = 32'h8000_0040;
    bus.req_wdata[1] = mk_line(2);
    bus.req_write[1] = 1'b1;
    sb.push_back(e);
    wait_cmd(ok);
    n_total++; if (!ok) $display("FAIL wr_cmd_timeout: got none want mem_write"); else n_pass++;
    n_total++; if (bus.mem_write !== sb[0].wr) $display("FAIL wr_mem_write: got %b want %b", bus.mem_write, sb[0].wr); else n_pass++;
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL wr_mem_read: got %b want 0", bus.mem_read); else n_pass++;
    n_total++; if (bus.mem_wdata !== sb[0].wdata) $display("FAIL wr_wdata: got %h want %h", bus.mem_wdata, sb[0].wdata); else n_pass++;
    n_total++; if (bus.mem_addr !== sb[0].addr) $display("FAIL wr_addr: got %h want %h", bus.mem_addr, sb[0].addr); else n_pass++;
    tick();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_resp !== sb[0].resp) $display("FAIL wr_resp: got %b want %b", bus.req_resp, sb[0].resp); else n_pass++;
    void'(sb.pop_front());
    tick();
    bus.mem_resp     = 1'b0;
    bus.req_write[1] = 1'b0;
  endtask

  task automatic test_contention();
    exp_t e;
    bit   ok;
    int   push_idx;
    int   p;
    idle_bus();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push_idx = 0;
    for (int q = 0; q < 2; q++) begin
      bus.req_addr[q] = 32'h1000_0007 + 32'(q) * 32'h100;
      bus.req_read[q] = 1'b1;
      e = '{resp: 2'(1 << q), addr: line_align(bus.req_addr[q]), wr: 1'b0, wdata: '0,
            rdata: mk_line(32'(100 + push_idx))};
      sb.push_back(e);
      push_idx++;
    end
    for (int k = 0; k < 4; k++) begin
      wait_cmd(ok);
      n_total++;
      if (!ok) begin
        $display("FAIL rr_cmd_timeout: txn %0d got none want command", k);
        break;
      end
      n_pass++;
      n_total++; if (bus.mem_addr !== sb[0].addr) $display("FAIL rr_addr: txn %0d got %h want %h", k, bus.mem_addr, sb[0].addr); else n_pass++;
      tick();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = mk_line(32'(100 + k));
      @(negedge clk);
      n_total++; if (bus.req_resp !== sb[0].resp) $display("FAIL rr_grant_order: txn %0d got %b want %b", k, bus.req_resp, sb[0].resp); else n_pass++;
      n_total++; if (bus.req_rdata !== sb[0].rdata) $display("FAIL rr_rdata: txn %0d got %h want %h", k, bus.req_rdata, sb[0].rdata); else n_pass++;
      p = sb[0].resp[1] ? 1 : 0;
      void'(sb.pop_front());
      tick();
      bus.mem_resp = 1'b0;
      if (k < 2) begin
        bus.req_addr[p] = 32'h2000_0013 + 32'(p) * 32'h100 + 32'(k) * 32'h40;
        e = '{resp: 2'(1 << p), addr: line_align(bus.req_addr[p]), wr: 1'b0, wdata: '0,
              rdata: mk_line(32'(100 + push_idx))};
        sb.push_back(e);
        push_idx++;
      end else begin
        bus.req_read[p] = 1'b0;
      end
      @(negedge clk);
      n_total++; if (bus.mem_read !== 1'b0) $display("FAIL rr_cmd_gap: txn %0d got %b want 0", k, bus.mem_read); else n_pass++;
    end
    sb.delete();
    idle_bus();
  endtask

  task automatic test_mid_wait_change();
    exp_t e;
    bit   ok;
    tick();
    bus.req_addr[0] = 32'h0000_2000;
    bus.req_read[0] = 1'b1;
    e = '{resp: 2'b01, addr: 32'h0000_2000, wr: 1'b0, wdata: '0, rdata: mk_line(3)};
    sb.push_back(e);
    wait_cmd(ok);
    n_total++; if (!ok || bus.mem_addr !== sb[0].addr) $display("FAIL mw_first_addr: got %h want %h", bus.mem_addr, sb[0].addr); else n_pass++;
    tick();
    bus.req_addr[1] = 32'h3333_3339;
    bus.req_read[1] = 1'b1;
    e = '{resp: 2'b10, addr: 32'h3333_3320, wr: 1'b0, wdata: '0, rdata: mk_line(4)};
    sb.push_back(e);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++; if (bus.mem_addr !== sb[0].addr) $display("FAIL mw_addr_held: cycle %0d got %h want %h", i, bus.mem_addr, sb[0].addr); else n_pass++;
      tick();
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = mk_line(3);
    @(negedge clk);
    n_total++; if (bus.req_resp !== sb[0].resp) $display("FAIL mw_resp0: got %b want %b", bus.req_resp, sb[0].resp); else n_pass++;
    void'(sb.pop_front());
    tick();
    bus.mem_resp    = 1'b0;
    bus.req_read[0] = 1'b0;
    @(negedge clk);
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL mw_gap: got %b want 0", bus.mem_read); else n_pass++;
    wait_cmd(ok);
    n_total++; if (!ok || bus.mem_addr !== sb[0].addr) $display("FAIL mw_second_addr: got %h want %h", bus.mem_addr, sb[0].addr); else n_pass++;
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = mk_line(4);
    @(negedge clk);
    n_total++; if (bus.req_resp !== sb[0].resp) $display("FAIL mw_resp1: got %b want %b", bus.req_resp, sb[0].resp); else n_pass++;
    n_total++; if (bus.req_rdata !== sb[0].rdata) $display("FAIL mw_rdata1: got %h want %h", bus.req_rdata, sb[0].rdata); else n_pass++;
    void'(sb.pop_front());
    tick();
    bus.mem_resp    = 1'b0;
    bus.req_read[1] = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    tick();
    bus.req_addr[0] = 32'h0000_4000;
    bus.req_read[0] = 1'b1;
    wait_cmd(ok);
    n_total++; if (!ok || bus.mem_read !== 1'b1) $display("FAIL ab_cmd: got %b want 1", bus.mem_read); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL ab_async_drop: got %b want 0", bus.mem_read); else n_pass++;
    tick();
    bus.req_read[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = mk_line(5);
    @(negedge clk);
    n_total++; if (bus.req_resp !== 2'b00) $display("FAIL ab_late_resp: got %b want 00", bus.req_resp); else n_pass++;
    tick();
    bus.mem_resp = 1'b0;
  endtask

  task automatic test_read_write_both();
    exp_t e;
    bit   ok;
    tick();
    bus.req_addr[0]  = 32'h5000_001F;
    bus.req_wdata[0] = mk_line(55);
    bus.req_read[0]  = 1'b1;
    bus.req_write[0] = 1'b1;
    e = '{resp: 2'b01, addr: 32'h5000_0000, wr: 1'b1, wdata: mk_line(55), rdata: '0};
    sb.push_back(e);
    wait_cmd(ok);
    n_total++; if (!ok || bus.mem_write !== sb[0].wr) $display("FAIL rw_write_wins: got %b want %b", bus.mem_write, sb[0].wr); else n_pass++;
    n_total++; if (bus.mem_read !== 1'b0) $display("FAIL rw_no_read: got %b want 0", bus.mem_read); else n_pass++;
    n_total++; if (bus.mem_addr !== sb[0].addr) $display("FAIL rw_addr: got %h want %h", bus.mem_addr, sb[0].addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== sb[0].wdata) $display("FAIL rw_wdata: got %h want %h", bus.mem_wdata, sb[0].wdata); else n_pass++;
    tick();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_resp !== sb[0].resp) $display("FAIL rw_resp: got %b want %b", bus.req_resp, sb[0].resp); else n_pass++;
    void'(sb.pop_front());
    tick();
    bus.mem_resp = 1'b0;
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_mid_wait_change();
    test_reset_abort();
    test_read_write_both();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
